// File: rtl/elastic_pipe_buffer.sv
// DEPTH-entry valid/ready elastic buffer with occupancy count, almost-full flag and synchronous flush.
// Circular buffer with explicit pointer wrap, so DEPTH need not be a power of two.
module elastic_pipe_buffer #(
    parameter int DATA_WIDTH         = 32,
    parameter int DEPTH              = 4,
    parameter int ALMOST_FULL_THRESH = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(ALMOST_FULL_THRESH);
    localparam logic [PW-1:0] LAST_C   = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          push, pop;

    // No pass-through when full: a pop at full frees a slot only for the next cycle.
    assign in_ready    = reset_n & ~flush & (count_reg != FULL_C);
    assign out_valid   = (count_reg != '0);
    assign push        = in_valid & in_ready;
    assign pop         = out_valid & out_ready;
    assign out_data    = mem[rd_ptr_reg];
    assign count       = count_reg;
    assign almost_full = (count_reg >= THRESH_C);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = (wr_ptr_reg == LAST_C) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == LAST_C) ? '0 : rd_ptr_reg + 1'b1;
        end
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Reset outranks flush; a pop coinciding with flush is discarded with the contents.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is deliberately not reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

endmodule

// File: tb/tb_elastic_pipe_buffer.sv
// Scoreboarded bench for elastic_pipe_buffer: stimulus queues expected words, a monitor checks every pop.
module tb_elastic_pipe_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  count;
    logic        almost_full;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q [$];

    elastic_pipe_buffer #(.DATA_WIDTH(32), .DEPTH(4), .ALMOST_FULL_THRESH(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a pop occurs at the next rising edge whenever out_valid & out_ready without flush.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && !flush && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", out_data, 32'hXXXX_XXXX);
                end else begin
                    check("pop_data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] fill_words [4];
        fill_words = '{32'h11, 32'h22, 32'h33, 32'h44};

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready",    32'(in_ready),    32'd0);
        check("rst_out_valid",   32'(out_valid),   32'd0);
        check("rst_count",       32'(count),       32'd0);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        tick();
        check("post_rst_count", 32'(count), 32'd0);

        // Single transfer
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hA5A5_0001;
        exp_q.push_back(32'hA5A5_0001);
        tick();
        in_valid = 1'b0;
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_count",     32'(count),     32'd1);
        tick();
        check("single_drained", 32'(count), 32'd0);

        // Fill under backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = fill_words[i];
            exp_q.push_back(fill_words[i]);
            tick();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_almost_full", 32'(almost_full), (i + 1 >= 3) ? 32'd1 : 32'd0);
        end
        in_data = 32'h55;
        check("full_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("full_hold_count", 32'(count),    32'd4);
        check("full_head_data",  out_data,      32'h11);
        check("full_hold_ready", 32'(in_ready), 32'd0);

        // Drain with wrap-around; no pass-through in the full cycle
        out_ready = 1'b1;
        #1;
        check("full_no_passthru", 32'(in_ready), 32'd0);
        tick();
        check("after_pop_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(32'h55);
        tick();
        in_data = 32'h66;
        exp_q.push_back(32'h66);
        tick();
        in_valid = 1'b0;
        check("wrap_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) tick();
        check("drain_count", 32'(count), 32'd0);

        // Streaming at one word per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            exp_q.push_back(32'(i));
            tick();
            check("stream_count", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_count", 32'(count), 32'd0);

        // Flush with three stored entries and a competing push
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA + 32'(i);
            tick();
        end
        check("preflush_count", 32'(count), 32'd3);
        flush   = 1'b1;
        in_data = 32'hD;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count",     32'(count),     32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        in_valid  = 1'b1;
        in_data   = 32'hE;
        out_ready = 1'b1;
        exp_q.push_back(32'hE);
        tick();
        in_valid = 1'b0;
        check("post_flush_head", out_data, 32'hE);
        tick();
        check("post_flush_count", 32'(count), 32'd0);

        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/elastic_pipe_buffer.md
Name: elastic_pipe_buffer

Overview:
Parametrised valid/ready elastic buffer. It generalises the single-entry pipeline register to DEPTH entries and sustains full throughput: one transfer in and one transfer out per cycle. It sits between any two streaming stages of the datapath to absorb downstream backpressure. It adds occupancy reporting, an almost-full flag and a synchronous flush.

Parameters:
DATA_WIDTH, 32, payload width in bits
DEPTH, 4, number of storage entries; minimum 2; need not be a power of two
ALMOST_FULL_THRESH, DEPTH-1, almost_full asserts when count >= this value; legal range 1..DEPTH

Ports:
clk  input  1  clock; all logic on rising edge
reset_n  input  1  synchronous reset, active-low
flush  input  1  synchronous clear of all stored entries
in_valid  input  1  upstream data valid
in_ready  output  1  buffer can accept data this cycle
in_data  input  DATA_WIDTH  upstream payload
out_valid  output  1  buffer holds at least one entry
out_ready  input  1  downstream accepts data this cycle
out_data  output  DATA_WIDTH  payload at head of buffer
count  output  $clog2(DEPTH+1)  current number of stored entries
almost_full  output  1  count >= ALMOST_FULL_THRESH

Behaviour:
- Reset: reset_n is synchronous, active-low; clock is clk. When reset_n=0 at a rising edge:
  - count=0, write and read pointers=0, out_valid=0, almost_full=0.
  - in_ready=0 combinationally while reset_n=0.
  - Storage array is not reset.
- Derived signals:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = reset_n & ~flush & (count != DEPTH).
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr] (combinational read of a registered array).
  - out_data is don't-care when out_valid=0.
- Latency: no bypass path. Data pushed at edge N is visible on out_data with out_valid=1 from edge N onward, so the first pop is possible in the cycle after the push. Minimum in-to-out latency is 1 cycle.
- Push: mem[wr_ptr] <= in_data; wr_ptr advances.
- Pop: rd_ptr advances.
- Pointer wrap: a pointer at DEPTH-1 goes to 0. Explicit compare; no power-of-two masking.
- Count update:
  - push & ~pop: +1.
  - pop & ~push: -1.
  - both or neither: unchanged.
- Full (count=DEPTH): in_ready=0 even if out_ready=1 in the same cycle; no full-state pass-through. A pop at full makes in_ready=1 the next cycle.
- Empty (count=0): out_valid=0; out_ready is ignored.
- Simultaneous push and pop at 0<count<DEPTH: both occur; count is unchanged; sustained 1 transfer per cycle.
- Flush=1 at an edge (reset_n=1):
  - Pointers and count go to 0; out_valid=0 next cycle.
  - No push occurs that cycle, because in_ready=0.
  - A pop indicated that cycle is discarded with the rest of the contents.
- Reset has priority over flush.
- Data stability: while out_valid=1 and out_ready=0, out_data and out_valid stay constant.
- Upstream contract: in_data is held stable under in_valid & ~in_ready. The buffer never drops or duplicates an accepted word.
- almost_full is combinational from count (same cycle as count).
- Reset or flush mid-burst: all in-flight entries are discarded; the next accepted word is the first one output.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, count=0, almost_full=0.
- Single transfer: out_ready=1, push 32'hA5A5_0001 at edge N -> out_valid=1 with out_data=A5A5_0001 after edge N, popped at edge N+1, count back to 0.
- Fill and backpressure (DEPTH=4): out_ready=0, push 11,22,33,44 on consecutive cycles -> count=1,2,3,4; almost_full=1 at count 3; in_ready=0 at count 4; a 5th word 55 held on in_data is not accepted; out_data stays 11.
- Drain with wrap-around: from full, set out_ready=1 and push 55,66 once in_ready=1 -> outputs in order 11,22,33,44,55,66, confirming pointer wrap at entry 3->0; count returns to 0.
- Streaming: in_valid=1 and out_ready=1 continuously for 20 words 0..19 -> after 1 cycle of latency, one word out per cycle, order preserved, count steady at 1.
- Flush: with 3 entries stored (A,B,C), assert flush for 1 cycle with in_valid=1, data D -> next cycle count=0, out_valid=0, D not stored; a subsequent push of E outputs E first.
